// File: rtl/interfpga_pkg.sv
// interfpga_pkg: shared types and constants for the inter-FPGA receive path
package interfpga_pkg;
  typedef enum logic {s_idle = 1'b0, s_ack = 1'b1} state_t;
  localparam int BYTE_W = 8;
  localparam int DEFAULT_DEPTH = 8;
endpackage

// File: rtl/interfpga_sync_fifo.sv
// interfpga_sync_fifo: byte FIFO; a push into a full FIFO is accepted only alongside a pop
module interfpga_sync_fifo
  import interfpga_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic              pop,
  output logic [BYTE_W-1:0] rd_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              accepted
);
  logic [BYTE_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic do_pop;
  assign empty = count == '0;
  assign full = count == (ADDR_W+1)'(DEPTH);
  assign do_pop = pop && !empty;
  assign accepted = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (accepted) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (accepted != do_pop) count <= accepted ? count + 1'b1 : count - 1'b1;
    end
  always_ff @(posedge clk)
    if (accepted) mem[wr_ptr] <= wr_data;
endmodule

// File: rtl/interfpga_rx_fifo.sv
// interfpga_rx_fifo: captures receiver bytes, pulses a registered ack, buffers them in a FIFO
module interfpga_rx_fifo
  import interfpga_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_ready,
  output logic              rx_ack,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_pop,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              overflow,
  input  logic              clr_overflow
);
  state_t state, next_state;
  logic capture, accepted, empty, drop;
  // rx_ready is ignored in s_ack so a clearing flag cannot be captured twice
  always_comb begin
    capture = (state == s_idle) && rx_ready;
    next_state = capture ? s_ack : s_idle;
  end
  assign drop = capture && !accepted;
  assign out_valid = !empty;
  // rx_ack must come straight from a flop: the receiver uses it as an async clear
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= s_idle;
      rx_ack <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= next_state;
      rx_ack <= capture;
      overflow <= drop ? 1'b1 : clr_overflow ? 1'b0 : overflow;
    end
  interfpga_sync_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fifo (
    .clk(clk),
    .reset_n(reset_n),
    .push(capture),
    .wr_data(rx_data),
    .pop(out_pop),
    .rd_data(out_data),
    .count(count),
    .full(full),
    .empty(empty),
    .accepted(accepted)
  );
endmodule

// File: tb/tb_interfpga_rx_fifo.sv
// tb_interfpga_rx_fifo: directed stimulus with a byte scoreboard checked on every pop
module tb_interfpga_rx_fifo;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_ready = 1'b0;
  logic       rx_ack;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_pop = 1'b0;
  logic [3:0] count;
  logic       full;
  logic       overflow;
  logic       clr_overflow = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  interfpga_rx_fifo dut (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_ready(rx_ready),
    .rx_ack(rx_ack), .out_data(out_data), .out_valid(out_valid), .out_pop(out_pop),
    .count(count), .full(full), .overflow(overflow), .clr_overflow(clr_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // every accepted pop must yield the oldest byte the bench expects to be stored
  always @(negedge clk)
    if (reset_n && out_valid && out_pop) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got %h expected nothing at %0t", out_data, $time);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          errors++;
          $display("FAIL pop_data: got %h expected %h at %0t", out_data, e, $time);
        end
      end
    end

  // receiver frame: ready for one cycle, cleared once the ack is seen
  task automatic send(input logic [7:0] b, input bit keep, input bit pop, input bit clr);
    @(posedge clk); #1;
    rx_data = b; rx_ready = 1'b1; out_pop = pop; clr_overflow = clr;
    if (keep) exp_q.push_back(b);
    chk("ack_idle", rx_ack, 0);
    @(posedge clk); #1;
    rx_ready = 1'b0; out_pop = 1'b0; clr_overflow = 1'b0;
    chk("ack_pulse", rx_ack, 1);
    @(posedge clk); #1;
    chk("ack_fall", rx_ack, 0);
    @(posedge clk);
  endtask

  task automatic pop_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1; out_pop = 1'b1;
      @(posedge clk); #1; out_pop = 1'b0;
    end
  endtask

  task automatic clr_pulse();
    @(posedge clk); #1; clr_overflow = 1'b1;
    @(posedge clk); #1; clr_overflow = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_ack", rx_ack, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0);
    reset_n = 1'b1;
    // single byte
    send(8'hA5, 1, 0, 0);
    chk("single_valid", out_valid, 1);
    chk("single_data", out_data, 8'hA5);
    chk("single_count", count, 1);
    pop_n(1);
    chk("single_count0", count, 0);
    chk("single_valid0", out_valid, 0);
    // streaming with wrap: each capture also pops the previous byte
    for (int i = 0; i < 12; i++) send(8'(i), 1, 1, 0);
    chk("wrap_count", count, 1);
    chk("wrap_ovf", overflow, 0);
    pop_n(1);
    chk("wrap_empty", out_valid, 0);
    // fill and overflow
    for (int i = 0; i < 8; i++) send(8'h10 + 8'(i), 1, 0, 0);
    chk("fill_full", full, 1);
    chk("fill_count", count, 8);
    chk("fill_ovf0", overflow, 0);
    send(8'h18, 0, 0, 0);
    chk("drop_ovf", overflow, 1);
    chk("drop_count", count, 8);
    pop_n(8);
    chk("drain_count", count, 0);
    clr_pulse();
    chk("clr_ovf", overflow, 0);
    // push with pop at full
    for (int i = 0; i < 8; i++) send(8'h20 + 8'(i), 1, 0, 0);
    send(8'hCC, 1, 1, 0);
    chk("pp_count", count, 8);
    chk("pp_full", full, 1);
    chk("pp_ovf", overflow, 0);
    pop_n(8);
    chk("pp_empty", out_valid, 0);
    // drop and clear together: set wins
    for (int i = 0; i < 8; i++) send(8'h30 + 8'(i), 1, 0, 0);
    send(8'h38, 0, 0, 1);
    chk("prio_ovf", overflow, 1);
    clr_pulse();
    chk("prio_clr", overflow, 0);
    // re-raise overflow, then reset mid-ack
    send(8'h39, 0, 0, 0);
    chk("pre_rst_ovf", overflow, 1);
    @(posedge clk); #1;
    rx_data = 8'h5A; rx_ready = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0;
    chk("mid_ack", rx_ack, 1);
    reset_n = 1'b0; #1;
    exp_q.delete();
    chk("mrst_ack", rx_ack, 0);
    chk("mrst_valid", out_valid, 0);
    chk("mrst_count", count, 0);
    chk("mrst_full", full, 0);
    chk("mrst_ovf", overflow, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    send(8'h77, 1, 0, 0);
    chk("post_data", out_data, 8'h77);
    pop_n(1);
    chk("post_count", count, 0);
    chk("queue_empty", 8'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
